// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the push-button conditioner.
// Board timing constants live here so the top-level defaults track the clock.
package btn_debounce_pkg;

  localparam int unsigned CLK_FREQ_HZ      = 65_000_000;
  localparam int unsigned DEBOUNCE_MS      = 10;
  localparam int unsigned REPEAT_DELAY_MS  = 500;
  localparam int unsigned REPEAT_PERIOD_MS = 100;

  localparam int unsigned DEBOUNCE_CYCLES      = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned REPEAT_DELAY_CYCLES  = (CLK_FREQ_HZ / 1000) * REPEAT_DELAY_MS;
  localparam int unsigned REPEAT_PERIOD_CYCLES = (CLK_FREQ_HZ / 1000) * REPEAT_PERIOD_MS;

  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_WAIT_FIRST = 2'd1,
    RPT_REPEATING  = 2'd2
  } rpt_state_e;

  // Counter width that can hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: synchroniser, stability filter, edge strobes and an
// optional auto-repeat timer.
module btn_debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s;
  logic                   rise, fall;
  logic                   rpt_fire;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign s      = sync_q[SYNC_STAGES-1];

  // Any cycle where s agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s;
        rise    = s;
        fall    = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_d   = rise | rpt_fire;
  assign release_d = fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int unsigned TW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    rpt_state_e      state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            fire;

    // A release takes priority so no repeat can share its cycle or follow it.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      fire    = 1'b0;
      if (fall) begin
        state_d = RPT_IDLE;
        tmr_d   = '0;
      end else if (rise) begin
        state_d = RPT_WAIT_FIRST;
        tmr_d   = TW'(REPEAT_DELAY - 1);
      end else begin
        case (state_q)
          RPT_WAIT_FIRST, RPT_REPEATING: begin
            if (level_q) begin
              if (tmr_q == '0) begin
                fire    = 1'b1;
                tmr_d   = TW'(REPEAT_PERIOD - 1);
                state_d = RPT_REPEATING;
              end else begin
                tmr_d = tmr_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= RPT_IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    assign rpt_fire = fire;
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: one independent channel per button,
// all channels in the core clock domain.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule
